// File: rtl/n101_regvec_arb_pkg.sv
// Shared types and constants for the register-vector write arbiter.
// The saturating increment is kept here so every user gets the same clamp behaviour.
package n101_regvec_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CHECK = 2'd2
  } state_e;

  typedef enum logic {
    REQ_BUS = 1'b0,
    REQ_HW  = 1'b1
  } req_id_e;

  localparam int                   ERR_CNT_W   = 4;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 4'd15;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/n101_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, and on a tie
// the requester that did not win last time is chosen.
module n101_rr_arb2
  import n101_regvec_arb_pkg::*;
(
  input  logic [1:0] req_i,       // [0] bus, [1] hw
  input  req_id_e    last_gnt_i,
  output req_id_e    gnt_id_o,
  output logic       any_o
);

  always_comb begin
    gnt_id_o = REQ_BUS;
    if (req_i == 2'b11) begin
      gnt_id_o = (last_gnt_i == REQ_BUS) ? REQ_HW : REQ_BUS;
    end else if (req_i[1]) begin
      gnt_id_o = REQ_HW;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/n101_regvec_wr_arb.sv
// Serialises bus and hardware writes into a bank of single-bit enable-gated cells,
// pulses one cell enable per write and reads the cell back to confirm the update.
//
// state | meaning
// IDLE  | waiting for a request; arbitrate and latch the winner
// GRANT | ready to the winner, enable pulse on the held cell
// CHECK | compare cell readback against the held data
module n101_regvec_wr_arb
  import n101_regvec_arb_pkg::*;
#(
  parameter  int NREG   = 8,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bus_valid_i,
  input  logic [ADDR_W-1:0]    bus_addr_i,
  input  logic                 bus_data_i,
  output logic                 bus_ready_o,
  input  logic                 hw_valid_i,
  input  logic [ADDR_W-1:0]    hw_addr_i,
  input  logic                 hw_data_i,
  output logic                 hw_ready_o,
  output logic [NREG-1:0]      reg_en_o,
  output logic [NREG-1:0]      reg_d_o,
  input  logic [NREG-1:0]      reg_q_i,
  output logic                 busy_o,
  output logic                 wr_err_o,
  input  logic                 err_clr_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     hold_addr_q, hold_addr_d;
  logic                  hold_data_q, hold_data_d;
  req_id_e               gnt_id_q, gnt_id_d;
  req_id_e               last_gnt_q, last_gnt_d;
  logic                  wr_err_q, wr_err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  req_id_e               arb_gnt;
  logic                  arb_any;
  logic                  mismatch;

  n101_rr_arb2 u_arb (
    .req_i      ({hw_valid_i, bus_valid_i}),
    .last_gnt_i (last_gnt_q),
    .gnt_id_o   (arb_gnt),
    .any_o      (arb_any)
  );

  assign mismatch = (state_q == CHECK) && (reg_q_i[hold_addr_q] != hold_data_q);

  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    gnt_id_d    = gnt_id_q;
    last_gnt_d  = last_gnt_q;
    wr_err_d    = wr_err_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          hold_addr_d = (arb_gnt == REQ_BUS) ? bus_addr_i : hw_addr_i;
          hold_data_d = (arb_gnt == REQ_BUS) ? bus_data_i : hw_data_i;
          gnt_id_d    = arb_gnt;
          last_gnt_d  = arb_gnt;
          state_d     = GRANT;
        end
      end
      GRANT:   state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A mismatch landing together with a clear takes precedence and counts as the first error.
    if (err_clr_i) begin
      wr_err_d  = 1'b0;
      err_cnt_d = '0;
    end
    if (mismatch) begin
      wr_err_d  = 1'b1;
      err_cnt_d = err_clr_i ? {{(ERR_CNT_W-1){1'b0}}, 1'b1} : sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_addr_q <= '0;
      hold_data_q <= 1'b0;
      gnt_id_q    <= REQ_BUS;
      last_gnt_q  <= REQ_HW;
      wr_err_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      gnt_id_q    <= gnt_id_d;
      last_gnt_q  <= last_gnt_d;
      wr_err_q    <= wr_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign bus_ready_o = (state_q == GRANT) && (gnt_id_q == REQ_BUS);
  assign hw_ready_o  = (state_q == GRANT) && (gnt_id_q == REQ_HW);
  assign reg_en_o    = (state_q == GRANT) ? (NREG'(1) << hold_addr_q) : '0;
  assign reg_d_o     = NREG'(hold_data_q) << hold_addr_q;
  assign wr_err_o    = wr_err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_n101_regvec_wr_arb.sv
// Scoreboard bench: directed stimulus queues expected grants and status snapshots,
// a negedge monitor pops and compares them as the arbiter presents them.
module tb_n101_regvec_wr_arb;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       bus_valid = 1'b0, hw_valid = 1'b0;
  logic [2:0] bus_addr = '0, hw_addr = '0;
  logic       bus_data = 1'b0, hw_data = 1'b0;
  logic       bus_ready, hw_ready;
  logic [7:0] reg_en, reg_d;
  logic [7:0] reg_q = '0;
  logic [7:0] stuck = '0;
  logic       busy, wr_err;
  logic       err_clr = 1'b0;
  logic [3:0] err_cnt;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int to_cnt = 0;
  bit done = 1'b0;
  bit final_done = 1'b0;

  typedef struct { int c; logic id; logic [2:0] a; logic d; } gnt_t;
  typedef struct { int c; logic busy; logic [1:0] rdy; logic [7:0] en; logic err; logic [3:0] cnt; } st_t;
  gnt_t gq[$];
  st_t  sq[$];
  gnt_t g;
  st_t  s;

  n101_regvec_wr_arb #(.NREG(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus_valid_i (bus_valid),
    .bus_addr_i  (bus_addr),
    .bus_data_i  (bus_data),
    .bus_ready_o (bus_ready),
    .hw_valid_i  (hw_valid),
    .hw_addr_i   (hw_addr),
    .hw_data_i   (hw_data),
    .hw_ready_o  (hw_ready),
    .reg_en_o    (reg_en),
    .reg_d_o     (reg_d),
    .reg_q_i     (reg_q),
    .busy_o      (busy),
    .wr_err_o    (wr_err),
    .err_clr_i   (err_clr),
    .err_cnt_o   (err_cnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Cell bank model; stuck cells ignore their enable.
  always @(posedge clock) begin
    for (int i = 0; i < 8; i++)
      if (reg_en[i] && !stuck[i]) reg_q[i] <= reg_d[i];
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  always @(negedge clock) begin
    while (sq.size() > 0 && sq[0].c < cyc) begin
      s = sq.pop_front();
      cmp("status_missed_cycle", cyc, s.c);
    end
    if (sq.size() > 0 && sq[0].c == cyc) begin
      s = sq.pop_front();
      cmp("busy", {31'd0, busy}, {31'd0, s.busy});
      cmp("ready", {30'd0, hw_ready, bus_ready}, {30'd0, s.rdy});
      cmp("reg_en", {24'd0, reg_en}, {24'd0, s.en});
      cmp("wr_err", {31'd0, wr_err}, {31'd0, s.err});
      cmp("err_cnt", {28'd0, err_cnt}, {28'd0, s.cnt});
    end
    cmp("reg_en_onehot0", ($countones(reg_en) <= 1) ? 32'd1 : 32'd0, 32'd1);
    while (gq.size() > 0 && gq[0].c < cyc) begin
      g = gq.pop_front();
      cmp("grant_missed_cycle", cyc, g.c);
    end
    if (bus_ready || hw_ready) begin
      if (gq.size() == 0) begin
        cmp("grant_unexpected", 32'd1, 32'd0);
      end else begin
        g = gq.pop_front();
        cmp("grant_cycle", cyc, g.c);
        cmp("grant_id", {30'd0, hw_ready, bus_ready}, g.id ? 32'd2 : 32'd1);
        cmp("grant_en", {24'd0, reg_en}, {24'd0, 8'b1 << g.a});
        cmp("grant_d", {31'd0, reg_d[g.a]}, {31'd0, g.d});
      end
    end
    if (done && !final_done) begin
      final_done = 1'b1;
      cmp("grants_left", gq.size(), 32'd0);
      cmp("status_left", sq.size(), 32'd0);
      cmp("handshake_timeouts", to_cnt, 32'd0);
    end
  end

  function automatic void pg(input int c, input logic id, input logic [2:0] a, input logic d);
    gq.push_back('{c: c, id: id, a: a, d: d});
  endfunction

  function automatic void ps(input int c, input logic b, input logic [1:0] r, input logic [7:0] e,
                             input logic er, input logic [3:0] n);
    sq.push_back('{c: c, busy: b, rdy: r, en: e, err: er, cnt: n});
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_valid = 1'b0;
    hw_valid = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [2:0] a, input logic d);
    if (id) begin
      hw_valid = v; hw_addr = a; hw_data = d;
    end else begin
      bus_valid = v; bus_addr = a; bus_data = d;
    end
  endtask

  // Keeps valid asserted across n writes, moving to the next address after each accept.
  task automatic stream(input logic id, input int n, input int a0, input int step, input logic d);
    set_req(id, 1'b1, 3'(a0), d);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      do begin
        @(negedge clock);
        w++;
      end while (!(id ? hw_ready : bus_ready) && w < 40);
      if (!(id ? hw_ready : bus_ready)) begin
        to_cnt++;
        $display("FAIL handshake_timeout id=%0d actual=no_ready required=ready", id);
        set_req(id, 1'b0, 3'd0, 1'b0);
        return;
      end
      tick();
      if (k == n - 1) set_req(id, 1'b0, 3'd0, 1'b0);
      else            set_req(id, 1'b1, 3'(a0 + (k + 1) * step), d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset();

    // single bus write, cell 3
    n = cyc;
    set_req(1'b0, 1'b1, 3'd3, 1'b1);
    pg(n + 1, 1'b0, 3'd3, 1'b1);
    ps(n,     1'b0, 2'b00, 8'h00, 1'b0, 4'd0);
    ps(n + 1, 1'b1, 2'b01, 8'h08, 1'b0, 4'd0);
    ps(n + 2, 1'b1, 2'b00, 8'h00, 1'b0, 4'd0);
    ps(n + 3, 1'b0, 2'b00, 8'h00, 1'b0, 4'd0);
    tick(); tick();
    set_req(1'b0, 1'b0, 3'd0, 1'b0);
    tick(); tick();

    // simultaneous requests after reset, then alternation
    do_reset();
    n = cyc;
    pg(n + 1,  1'b0, 3'd1, 1'b1);
    pg(n + 4,  1'b1, 3'd6, 1'b1);
    pg(n + 7,  1'b0, 3'd2, 1'b1);
    pg(n + 10, 1'b1, 3'd7, 1'b1);
    ps(n + 1, 1'b1, 2'b01, 8'h02, 1'b0, 4'd0);
    ps(n + 4, 1'b1, 2'b10, 8'h40, 1'b0, 4'd0);
    fork
      stream(1'b0, 2, 1, 1, 1'b1);
      stream(1'b1, 2, 6, 1, 1'b1);
    join
    tick();

    // forced mismatch on cell 5, then saturation
    do_reset();
    stuck[5] = 1'b1;
    n = cyc;
    pg(n + 1, 1'b0, 3'd5, 1'b1);
    ps(n + 2, 1'b1, 2'b00, 8'h00, 1'b0, 4'd0);
    ps(n + 3, 1'b0, 2'b00, 8'h00, 1'b1, 4'd1);
    for (int k = 0; k < 20; k++) pg(n + 4 + 3 * k, 1'b0, 3'd5, 1'b1);
    ps(n + 63, 1'b0, 2'b00, 8'h00, 1'b1, 4'd15);
    stream(1'b0, 1, 5, 0, 1'b1);
    stream(1'b0, 20, 5, 0, 1'b1);
    tick();

    // clear coinciding with a mismatch, then clear alone
    n = cyc;
    set_req(1'b0, 1'b1, 3'd5, 1'b1);
    pg(n + 1, 1'b0, 3'd5, 1'b1);
    ps(n + 2, 1'b1, 2'b00, 8'h00, 1'b1, 4'd15);
    ps(n + 3, 1'b0, 2'b00, 8'h00, 1'b1, 4'd1);
    ps(n + 4, 1'b0, 2'b00, 8'h00, 1'b0, 4'd0);
    tick(); tick();
    set_req(1'b0, 1'b0, 3'd0, 1'b0);
    err_clr = 1'b1;
    tick(); tick();
    err_clr = 1'b0;

    // reset during GRANT; request stays valid and is regranted
    n = cyc;
    set_req(1'b0, 1'b1, 3'd4, 1'b1);
    pg(n + 1, 1'b0, 3'd4, 1'b1);
    pg(n + 3, 1'b0, 3'd4, 1'b1);
    ps(n + 1, 1'b1, 2'b01, 8'h10, 1'b0, 4'd0);
    ps(n + 2, 1'b0, 2'b00, 8'h00, 1'b0, 4'd0);
    ps(n + 3, 1'b1, 2'b01, 8'h10, 1'b0, 4'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    set_req(1'b0, 1'b0, 3'd0, 1'b0);
    tick();

    // hw-only stream of four writes
    n = cyc;
    for (int k = 0; k < 4; k++) pg(n + 1 + 3 * k, 1'b1, 3'(k), 1'b0);
    ps(n + 1,  1'b1, 2'b10, 8'h01, 1'b0, 4'd0);
    ps(n + 10, 1'b1, 2'b10, 8'h08, 1'b0, 4'd0);
    ps(n + 13, 1'b0, 2'b00, 8'h00, 1'b0, 4'd0);
    stream(1'b1, 4, 0, 1, 1'b0);
    tick(); tick();
    done = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
